// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DefaultDataStreak = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port. Data wins, but
// only for DATA_STREAK back-to-back grants while a fetch is waiting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_STREAK = DefaultDataStreak,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned StreakW = $clog2(DATA_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(DATA_STREAK);

  arb_state_e         state_q;
  logic [StreakW-1:0] streak_q;
  logic               cancel_q;
  logic               grant_d;
  logic               grant_i;

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == StIdle) begin
      if (d_req && (streak_q < StreakMax)) begin
        grant_d = 1'b1;
      end else if (if_req && !if_flush) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      streak_q  <= '0;
      cancel_q  <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q   <= StBusyD;
            mem_valid <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // Streak only counts grants that actually made a fetch wait.
            if (!if_req) begin
              streak_q <= '0;
            end else if (streak_q != StreakMax) begin
              streak_q <= streak_q + 1'b1;
            end
          end else if (grant_i) begin
            state_q   <= StBusyI;
            mem_valid <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            streak_q  <= '0;
            cancel_q  <= 1'b0;
          end
        end
        StBusyI: begin
          if (mem_ready) begin
            state_q   <= StIdle;
            mem_valid <= 1'b0;
            // A flush in the completion cycle still cancels the fetch.
            if (!(cancel_q || if_flush)) begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (if_flush) begin
            cancel_q <= 1'b1;
          end
        end
        StBusyD: begin
          if (mem_ready) begin
            state_q   <= StIdle;
            mem_valid <= 1'b0;
            d_done    <= 1'b1;
            d_rdata   <= mem_rdata;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: request agents, a latency-programmable memory model
// and a grant/completion scoreboard checked on the falling clock edge.
module tb_mem_port_arbiter;

  typedef struct {
    logic        fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        cancel;
  } grant_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned lat;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_valid, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  grant_t      exp_q[$];
  dreq_t       dq[$];
  logic [31:0] fq[$];
  logic [31:0] mem_store[logic [31:0]];
  int unsigned mem_lat = 2;
  logic        spurious = 1'b0;

  mem_port_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .mem_valid(mem_valid),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata);
    grant_t g;
    g.fetch = 1'b0; g.we = we; g.addr = addr; g.wdata = wdata; g.rdata = rdata;
    g.cancel = 1'b0;
    exp_q.push_back(g);
  endtask

  task automatic push_i(input logic [31:0] addr, input logic [31:0] rdata, input logic cancel);
    grant_t g;
    g.fetch = 1'b1; g.we = 1'b0; g.addr = addr; g.wdata = '0; g.rdata = rdata;
    g.cancel = cancel;
    exp_q.push_back(g);
  endtask

  task automatic req_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    dreq_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    dq.push_back(r);
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int unsigned lat, input logic [31:0] exp_rdata);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.lat = lat; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Memory model: mem_ready after mem_lat cycles of mem_valid; stores return rdata 0.
  initial begin
    int unsigned lat_cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    mem_store[32'h10]  = 32'h0000_0013;
    mem_store[32'h20]  = 32'h0010_0093;
    mem_store[32'h100] = 32'h1234_5678;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (mem_valid) begin
        lat_cnt++;
        if (lat_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          lat_cnt   = 0;
          if (mem_we) mem_store[mem_addr] = mem_wdata;
          else mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : ~mem_addr;
        end
      end else begin
        lat_cnt = 0;
        if (spurious) begin
          mem_ready = 1'b1;
          mem_rdata = 32'h5555_AAAA;
        end
      end
    end
  end

  // Data agent: holds the queue head until d_done, then presents the next one at once.
  initial begin
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (d_done && dq.size() > 0) void'(dq.pop_front());
      if (dq.size() > 0) begin
        d_req = 1'b1; d_we = dq[0].we; d_addr = dq[0].addr; d_wdata = dq[0].wdata;
      end else begin
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      end
    end
  end

  // Fetch agent; a flush redirect is modelled by rewriting the queue head.
  initial begin
    if_req = 1'b0; if_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (if_done && fq.size() > 0) void'(fq.pop_front());
      if (fq.size() > 0) begin
        if_req = 1'b1; if_addr = fq[0];
      end else begin
        if_req = 1'b0; if_addr = '0;
      end
    end
  end

  // Scoreboard monitor.
  grant_t      cur;
  logic        have_cur = 1'b0;
  logic        prev_valid = 1'b0;
  logic        due_d = 1'b0, due_i = 1'b0;
  logic [31:0] due_rdata = '0, exp_d_rdata = '0, exp_if_rdata = '0;
  int          cyc = 0, valid_len = 0, d_done_cyc = 0, fetch_grant_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      have_cur = 1'b0; prev_valid = 1'b0; due_d = 1'b0; due_i = 1'b0;
      exp_d_rdata = '0; exp_if_rdata = '0; valid_len = 0;
    end else begin
      if (due_d) exp_d_rdata = due_rdata;
      if (due_i) exp_if_rdata = due_rdata;
      check("d_done", 32'(d_done), 32'(due_d));
      check("if_done", 32'(if_done), 32'(due_i));
      check("d_rdata", d_rdata, exp_d_rdata);
      check("if_rdata", if_rdata, exp_if_rdata);
      if (d_done) d_done_cyc = cyc;
      due_d = 1'b0;
      due_i = 1'b0;
      if (mem_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL grant_order: got unexpected grant addr %h expected no grant", mem_addr);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          valid_len = 0;
          if (cur.fetch) fetch_grant_cyc = cyc;
        end
      end
      if (mem_valid && have_cur) begin
        valid_len++;
        check("mem_we", 32'(mem_we), 32'(cur.we));
        check("mem_addr", mem_addr, cur.addr);
        check("mem_wdata", mem_wdata, cur.wdata);
        if (mem_ready) begin
          check("valid_len", 32'(valid_len), 32'(mem_lat));
          due_d = !cur.fetch;
          due_i = cur.fetch && !cur.cancel;
          due_rdata = cur.rdata;
          have_cur = 1'b0;
        end
      end
      prev_valid = mem_valid;
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || dq.size() != 0 || fq.size() != 0 || mem_valid || have_cur)
           && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout with %0d grants outstanding, expected 0", name, exp_q.size());
      exp_q.delete(); dq.delete(); fq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!mem_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: mem_valid got 0 expected 1 within 100 cycles", name);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation got stuck, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    int n;
    reset = 1'b1;
    if_flush = 1'b0;
    vecs[0] = mk(1'b1, 32'h200, 32'hDEAD_BEEF, 3, 32'h0);
    vecs[1] = mk(1'b0, 32'h200, 32'h0,         1, 32'hDEAD_BEEF);
    vecs[2] = mk(1'b0, 32'h100, 32'h0,         2, 32'h1234_5678);
    vecs[3] = mk(1'b1, 32'h104, 32'hCAFE_F00D, 1, 32'h0);
    vecs[4] = mk(1'b0, 32'h104, 32'h0,         4, 32'hCAFE_F00D);
    vecs[5] = mk(1'b0, 32'h300, 32'h0,         1, 32'hFFFF_FCFF);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_dones", 32'({if_done, d_done}), 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    reset = 1'b0;

    // Single fetch, latency 2.
    @(negedge clk);
    mem_lat = 2;
    push_i(32'h10, 32'h0000_0013, 1'b0);
    fq.push_back(32'h10);
    wait_drain("single_fetch");
    check("single_fetch_rdata", if_rdata, 32'h0000_0013);

    // Table of isolated data transactions.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_lat = vecs[i].lat;
      push_d(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      req_d(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      wait_drain("data_vec");
      check("vec_d_rdata", d_rdata, vecs[i].exp_rdata);
    end

    // Simultaneous requests: data first, fetch in the d_done cycle's edge.
    @(negedge clk);
    mem_lat = 2;
    push_d(1'b0, 32'h100, 32'h0, 32'h1234_5678);
    push_i(32'h20, 32'h0010_0093, 1'b0);
    req_d(1'b0, 32'h100, 32'h0);
    fq.push_back(32'h20);
    wait_drain("simultaneous");
    check("fetch_after_d_done", 32'(fetch_grant_cyc - d_done_cyc), 32'd1);

    // Starvation: 10 stores vs 2 fetches -> D D D D I D D D D I D D.
    @(negedge clk);
    mem_lat = 1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 4) push_i(32'h30, 32'hFFFF_FFCF, 1'b0);
      else if (k == 9) push_i(32'h34, 32'hFFFF_FFCB, 1'b0);
      else begin
        push_d(1'b1, 32'h400 + 32'(4 * n), 32'hA000_0000 + 32'(n), 32'h0);
        req_d(1'b1, 32'h400 + 32'(4 * n), 32'hA000_0000 + 32'(n));
        n++;
      end
    end
    fq.push_back(32'h30);
    fq.push_back(32'h34);
    wait_drain("starvation");

    // Flush during the second busy cycle of a fetch.
    @(negedge clk);
    mem_lat = 3;
    push_i(32'h40, 32'hFFFF_FFBF, 1'b1);
    push_i(32'h80, 32'hFFFF_FF7F, 1'b0);
    fq.push_back(32'h40);
    wait_valid("flush_mid");
    @(posedge clk); #2;
    if_flush = 1'b1;
    fq[0] = 32'h80;
    @(posedge clk); #2;
    if_flush = 1'b0;
    wait_drain("flush_mid");
    check("flush_mid_rdata", if_rdata, 32'hFFFF_FF7F);

    // Flush in the very cycle mem_ready arrives.
    @(negedge clk);
    push_i(32'h48, 32'hFFFF_FFB7, 1'b1);
    push_i(32'h88, 32'hFFFF_FF77, 1'b0);
    fq.push_back(32'h48);
    wait_valid("flush_ready");
    @(posedge clk);
    @(posedge clk); #2;
    if_flush = 1'b1;
    fq[0] = 32'h88;
    @(posedge clk); #2;
    if_flush = 1'b0;
    wait_drain("flush_ready");
    check("flush_ready_rdata", if_rdata, 32'hFFFF_FF77);

    // Flush while idle blocks the grant for that cycle only.
    @(negedge clk);
    mem_lat = 1;
    push_i(32'h90, 32'hFFFF_FF6F, 1'b0);
    fq.push_back(32'h90);
    if_flush = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    if_flush = 1'b0;
    @(negedge clk);
    check("idle_flush_blocks", 32'(mem_valid), 32'h0);
    @(negedge clk);
    check("grant_after_idle_flush", 32'(mem_valid), 32'h1);
    wait_drain("idle_flush");

    // mem_ready while idle is ignored.
    @(negedge clk);
    spurious = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("spurious_dones", 32'({if_done, d_done}), 32'h0);
      check("spurious_d_rdata", d_rdata, 32'h0);
    end
    spurious = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during BUSY_D with streak at 3; the streak must restart from 0.
    @(negedge clk);
    mem_lat = 4;
    for (int k = 0; k < 3; k++) begin
      push_d(1'b0, 32'h100, 32'h0, 32'h1234_5678);
      req_d(1'b0, 32'h100, 32'h0);
    end
    fq.push_back(32'h50);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL reset_setup: got %0d grants pending expected 0", exp_q.size());
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) req_d(1'b0, 32'h100, 32'h0);
    for (int k = 0; k < 6; k++) begin
      if (k == 4) push_i(32'h50, 32'hFFFF_FFAF, 1'b0);
      else push_d(1'b0, 32'h100, 32'h0, 32'h1234_5678);
    end
    @(posedge clk);
    @(negedge clk);
    check("reset_mem_valid", 32'(mem_valid), 32'h0);
    check("reset_d_done", 32'(d_done), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_mem_valid", 32'(mem_valid), 32'h0);
    check("post_reset_d_done", 32'(d_done), 32'h0);
    check("post_reset_d_rdata", d_rdata, 32'h0);
    wait_drain("reset_streak");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
